// File: rtl/expect_vector_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : expect_vector_checker
// Description : Reads the ID/version header from the vector memory, compares
//               each expected vector against a DUT result on valid/ready,
//               and reports mismatch statistics plus a pass/fail verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module expect_vector_checker #(
    parameter int VEC_WIDTH   = 32,
    parameter int NUM_VECTORS = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int MAX_ERRORS  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic                 rd_en,
    input  logic [VEC_WIDTH-1:0] vector_in,
    input  logic                 vector_valid,
    input  logic                 id_err,
    input  logic                 version_err,
    input  logic                 dut_valid,
    input  logic [VEC_WIDTH-1:0] dut_data,
    output logic                 dut_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 header_err,
    output logic                 protocol_err,
    output logic [CNT_WIDTH-1:0] mismatch_count,
    output logic [CNT_WIDTH-1:0] vec_index,
    output logic [CNT_WIDTH-1:0] first_mis_index,
    output logic [VEC_WIDTH-1:0] first_mis_expected,
    output logic [VEC_WIDTH-1:0] first_mis_actual
);

    localparam logic [CNT_WIDTH-1:0] c_num_vectors = CNT_WIDTH'(NUM_VECTORS);
    localparam logic [CNT_WIDTH-1:0] c_max_errors  = CNT_WIDTH'(MAX_ERRORS);
    localparam bit                   c_early_stop  = (MAX_ERRORS != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRIME   = 3'd1,
        S_CHK_ID  = 3'd2,
        S_CHK_VER = 3'd3,
        S_RUN     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_id_err;
    logic                 r_dut_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic                 r_header_err;
    logic                 r_protocol_err;
    logic [CNT_WIDTH-1:0] r_mismatch_count;
    logic [CNT_WIDTH-1:0] r_vec_index;
    logic [CNT_WIDTH-1:0] r_first_mis_index;
    logic [VEC_WIDTH-1:0] r_first_mis_expected;
    logic [VEC_WIDTH-1:0] r_first_mis_actual;

    // A beat with no valid memory word counts as a mismatch as well
    logic                 w_mis;
    logic                 w_first;
    logic [CNT_WIDTH-1:0] w_mis_next;
    logic [CNT_WIDTH-1:0] w_idx_next;
    logic                 w_prot_next;
    logic                 w_hit_end;
    logic                 w_hit_max;
    logic                 w_end;

    assign w_mis       = !vector_valid || (vector_in != dut_data);
    assign w_first     = w_mis && (r_mismatch_count == '0);
    assign w_mis_next  = (w_mis && !(&r_mismatch_count)) ? r_mismatch_count + 1'b1
                                                         : r_mismatch_count;
    assign w_idx_next  = r_vec_index + 1'b1;
    assign w_prot_next = r_protocol_err || !vector_valid;
    assign w_hit_end   = (w_idx_next == c_num_vectors);
    assign w_hit_max   = c_early_stop && (w_mis_next >= c_max_errors);
    assign w_end       = w_hit_end || w_hit_max;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state              <= S_IDLE;
            r_id_err             <= 1'b0;
            r_dut_ready          <= 1'b0;
            r_busy               <= 1'b0;
            r_done               <= 1'b0;
            r_pass               <= 1'b0;
            r_header_err         <= 1'b0;
            r_protocol_err       <= 1'b0;
            r_mismatch_count     <= '0;
            r_vec_index          <= '0;
            r_first_mis_index    <= '0;
            r_first_mis_expected <= '0;
            r_first_mis_actual   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_PRIME;
                        r_busy  <= 1'b1;
                    end
                end
                S_PRIME: begin
                    r_state <= S_CHK_ID;
                end
                S_CHK_ID: begin
                    r_id_err <= id_err;
                    r_state  <= S_CHK_VER;
                end
                S_CHK_VER: begin
                    if (r_id_err || version_err) begin
                        r_header_err <= 1'b1;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_pass       <= 1'b0;
                        r_state      <= S_DONE;
                    end else begin
                        r_dut_ready <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (dut_valid) begin
                        r_vec_index      <= w_idx_next;
                        r_mismatch_count <= w_mis_next;
                        r_protocol_err   <= w_prot_next;
                        if (w_first) begin
                            r_first_mis_index    <= r_vec_index;
                            r_first_mis_expected <= vector_in;
                            r_first_mis_actual   <= dut_data;
                        end
                        if (w_end) begin
                            r_dut_ready <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_pass      <= !r_header_err && !w_prot_next &&
                                           (w_mis_next == '0);
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Header strobes come from the state; in RUN the read follows each accepted beat
    assign rd_en = (r_state == S_PRIME) || (r_state == S_CHK_ID) ||
                   (r_state == S_CHK_VER) || (r_dut_ready && dut_valid);

    assign dut_ready          = r_dut_ready;
    assign busy               = r_busy;
    assign done               = r_done;
    assign pass               = r_pass;
    assign header_err         = r_header_err;
    assign protocol_err       = r_protocol_err;
    assign mismatch_count     = r_mismatch_count;
    assign vec_index          = r_vec_index;
    assign first_mis_index    = r_first_mis_index;
    assign first_mis_expected = r_first_mis_expected;
    assign first_mis_actual   = r_first_mis_actual;

endmodule
`default_nettype wire
